athena_color_mixer: RTL

Final pixel stage of the Athena video path, directly downstream of the side layer. Each pixel it merges the side layer's 7-bit colour code with the sprite and background codes and applies fixed transparency and priority rules. It looks the winning code up in the three 1Kx4 colour PROMs, which are loaded through hps_io. It then outputs registered 4:4:4 RGB with blanking aligned to the pixel.

---
 rtl/athena_color_mixer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/athena_color_mixer.sv
// Athena final pixel stage: layer priority mux, 1Kx4 R/G/B colour PROMs loaded over hps_io,
// registered 4:4:4 output with aligned blanking. Define ATHENA_MIXER_DEBUG_EN to honour LAYER_EN.
module athena_color_mixer #(
  parameter logic [24:0] PROM_BASE = 25'h3C_000,
  parameter logic [3:0]  TRANSP    = 4'hF
) (
  input  logic        clk,
  input  logic        VIDEO_RST,
  input  logic        PIX_CEN,
  input  logic [6:0]  SD,
  input  logic [6:0]  SPR_D,
  input  logic [7:0]  BG_D,
  input  logic        SPR_OVER_SIDE,
  input  logic        HBLANK,
  input  logic        VBLANK,
  input  logic [2:0]  LAYER_EN,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_downl,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HBL_O,
  output logic        VBL_O
);

  logic side_en, spr_en, bg_en;
`ifdef ATHENA_MIXER_DEBUG_EN
  // Enables are sampled on PIX_CEN together with the colour codes via the stage-1 address register.
  assign {side_en, spr_en, bg_en} = LAYER_EN;
`else
  assign {side_en, spr_en, bg_en} = 3'b111;
  logic unused_layer_en;
  assign unused_layer_en = ^LAYER_EN;
`endif

  logic unused_data_hi;
  assign unused_data_hi = ^ioctl_data[7:4];

  function automatic logic [3:0] kill_nib(input logic [3:0] v, input logic kill);
    return kill ? 4'h0 : v;
  endfunction

  logic       side_opq, spr_opq;
  logic [9:0] bg_addr;
  logic [9:0] pal_addr_d;

  always_comb begin
    side_opq   = side_en && (SD[3:0] != TRANSP);
    spr_opq    = spr_en && (SPR_D[3:0] != TRANSP);
    bg_addr    = bg_en ? {2'b00, BG_D} : 10'h000;
    pal_addr_d = bg_addr;
    if (SPR_OVER_SIDE) begin
      if (spr_opq)       pal_addr_d = {3'b010, SPR_D};
      else if (side_opq) pal_addr_d = {3'b100, SD};
    end else begin
      if (side_opq)      pal_addr_d = {3'b100, SD};
      else if (spr_opq)  pal_addr_d = {3'b010, SPR_D};
    end
  end

  // Stage 1: palette address and blanking captured on PIX_CEN
  logic [9:0] pal_addr_p1_q;
  logic       hbl_p1_q, vbl_p1_q, vld_p1_q;

  always_ff @(posedge clk) begin
    if (PIX_CEN) pal_addr_p1_q <= pal_addr_d;
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      vld_p1_q <= 1'b0;
      hbl_p1_q <= 1'b1;
      vbl_p1_q <= 1'b1;
    end else if (PIX_CEN) begin
      vld_p1_q <= 1'b1;
      hbl_p1_q <= HBLANK;
      vbl_p1_q <= VBLANK;
    end
  end

  // PROM write port, independent of the pixel enable
  logic [3:0]  prom_r [1024];
  logic [3:0]  prom_g [1024];
  logic [3:0]  prom_b [1024];
  logic [24:0] prom_off;
  logic        wr_hit;

  assign prom_off = ioctl_addr - PROM_BASE;
  assign wr_hit   = ioctl_wr && (ioctl_addr >= PROM_BASE) && (prom_off < 25'hC00);

  always_ff @(posedge clk) begin
    if (wr_hit && prom_off[11:10] == 2'd0) prom_r[prom_off[9:0]] <= ioctl_data[3:0];
    if (wr_hit && prom_off[11:10] == 2'd1) prom_g[prom_off[9:0]] <= ioctl_data[3:0];
    if (wr_hit && prom_off[11:10] == 2'd2) prom_b[prom_off[9:0]] <= ioctl_data[3:0];
  end

  // Stage 2: synchronous PROM read; a same-cycle write to the entry is seen only next cycle
  logic [3:0] r_p2_q, g_p2_q, b_p2_q;

  always_ff @(posedge clk) begin
    r_p2_q <= prom_r[pal_addr_p1_q];
    g_p2_q <= prom_g[pal_addr_p1_q];
    b_p2_q <= prom_b[pal_addr_p1_q];
  end

  // Download hold: black out the picture while the PROMs are being rewritten
  logic hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (PIX_CEN && !ioctl_downl) hold_d = 1'b0;
    if (ioctl_downl && wr_hit)   hold_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) hold_q <= 1'b0;
    else           hold_q <= hold_d;
  end

  // Stage 3: output registers, updated on PIX_CEN only
  logic [3:0] r_q, g_q, b_q;
  logic       hbl_q, vbl_q;
  logic       kill_p2;

  assign kill_p2 = hold_q || hbl_p1_q || vbl_p1_q;

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      r_q   <= 4'h0;
      g_q   <= 4'h0;
      b_q   <= 4'h0;
      hbl_q <= 1'b1;
      vbl_q <= 1'b1;
    end else if (PIX_CEN) begin
      if (!vld_p1_q) begin
        r_q   <= 4'h0;
        g_q   <= 4'h0;
        b_q   <= 4'h0;
        hbl_q <= 1'b1;
        vbl_q <= 1'b1;
      end else begin
        r_q   <= kill_nib(r_p2_q, kill_p2);
        g_q   <= kill_nib(g_p2_q, kill_p2);
        b_q   <= kill_nib(b_p2_q, kill_p2);
        hbl_q <= hbl_p1_q;
        vbl_q <= vbl_p1_q;
      end
    end
  end

  assign R     = r_q;
  assign G     = g_q;
  assign B     = b_q;
  assign HBL_O = hbl_q;
  assign VBL_O = vbl_q;

endmodule
